// File: rtl/prog_lut_pkg.sv
// Shared types and the power-on default image for the programmable lookup table.
package prog_lut_pkg;

  localparam int DEFAULT_LEN = 31;

  // Entries 0-15 are datapath constants, 16-30 are branch targets.
  localparam logic [7:0] DEFAULT_IMAGE [DEFAULT_LEN] = '{
    8'h20, 8'h21, 8'h22, 8'h23, 8'h40, 8'h5B, 8'h6D, 8'h8E,
    8'hA8, 8'hAA, 8'hC8, 8'hCC, 8'hE0, 8'hE8, 8'hF0, 8'hFE,
    8'd2,  8'd4,  8'd104, 8'd137, 8'd141, 8'd145, 8'd147, 8'd154,
    8'd9,  8'd17, 8'd58,  8'd68,  8'd110, 8'd120, 8'd136
  };

  typedef enum logic {INIT, READY} lut_state_t;

  function automatic logic [7:0] default_entry(input logic [31:0] idx);
    if (idx < DEFAULT_LEN) return DEFAULT_IMAGE[idx[4:0]];
    return 8'h00;
  endfunction

endpackage

// File: rtl/lut_init_seq.sv
// Init/ready sequencer: walks the table once after reset or init_req,
// emitting one default-image write per cycle.
module lut_init_seq
  import prog_lut_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_req,
  output logic              busy,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic [DATA_W-1:0] init_data
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  lut_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [DATA_W+7:0] img_wide;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    init_we    = 1'b0;
    case (state_reg)
      INIT: begin
        init_we = 1'b1;
        if (cnt_reg == LAST) begin
          state_next = READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      READY: begin
        if (init_req) begin
          state_next = INIT;
          cnt_next   = '0;
        end
      end
      default: state_next = INIT;
    endcase
  end

  // Widen before slicing so DATA_W below or above 8 both work.
  assign img_wide  = {{DATA_W{1'b0}}, default_entry(32'(cnt_reg))};
  assign init_data = img_wide[DATA_W-1:0];
  assign init_addr = cnt_reg;
  assign busy      = (state_reg == INIT);

endmodule

// File: rtl/prog_lut.sv
// Runtime-programmable lookup table with registered reads.
// Define PROG_LUT_FWD_EN for write-first forwarding on same-key read/write.
module prog_lut
  import prog_lut_pkg::*;
#(
  parameter int KEY_W  = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_req,
  output logic              busy,
  input  logic              rd_en,
  input  logic [KEY_W-1:0]  rd_key,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_oor,
  input  logic              wr_en,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [KEY_W:0] DEPTH_K = (KEY_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  logic              accept, rd_go, wr_go, rd_in_range, wr_in_range, fwd_hit;

  lut_init_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_seq (
    .clk       (clk),
    .reset     (reset),
    .init_req  (init_req),
    .busy      (busy),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  // init_req wins over any user access issued in the same cycle.
  assign accept      = ~busy & ~init_req;
  assign rd_in_range = {1'b0, rd_key} < DEPTH_K;
  assign wr_in_range = {1'b0, wr_key} < DEPTH_K;
  assign rd_go       = accept & rd_en;
  assign wr_go       = accept & wr_en & wr_in_range;

`ifdef PROG_LUT_FWD_EN
  assign fwd_hit = wr_go & (wr_key == rd_key);
`else
  assign fwd_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (init_we)
      mem[init_addr] <= init_data;
    else if (wr_go)
      mem[wr_key[ADDR_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_oor   <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      if (rd_go) begin
        if (!rd_in_range) begin
          rd_data <= '0;
          rd_oor  <= 1'b1;
        end else begin
          rd_data <= fwd_hit ? wr_data : mem[rd_key[ADDR_W-1:0]];
          rd_oor  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_lut.sv
// Directed bench for prog_lut: scoreboard of expected reads, checked when rd_valid fires.
module tb_prog_lut;

  localparam int KEY_W  = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              oor;
    logic [KEY_W-1:0]  key;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset, init_req, busy;
  logic              rd_en, rd_valid, rd_oor, wr_en;
  logic [KEY_W-1:0]  rd_key, wr_key;
  logic [DATA_W-1:0] rd_data, wr_data;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic pend = 1'b0;
  int   n;

  always #5 clk = ~clk;

  prog_lut #(.KEY_W(KEY_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .init_req (init_req),
    .busy     (busy),
    .rd_en    (rd_en),
    .rd_key   (rd_key),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_oor   (rd_oor),
    .wr_en    (wr_en),
    .wr_key   (wr_key),
    .wr_data  (wr_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock; afterwards compare rd_valid and any scoreboard entry.
  task automatic tick();
    logic exp_v;
    exp_t e;
    exp_v = pend;
    pend  = 1'b0;
    @(posedge clk);
    #1;
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, exp_v});
    if (rd_valid === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk("rd_data", {24'b0, rd_data}, {24'b0, e.data});
      chk("rd_oor", {31'b0, rd_oor}, {31'b0, e.oor});
      $display("read key=%0d data=%02h oor=%0b (exp %02h/%0b)", e.key, rd_data, rd_oor, e.data, e.oor);
    end
  endtask

  task automatic do_read(input logic [KEY_W-1:0] key, input logic [DATA_W-1:0] d, input logic oor);
    exp_t e;
    rd_en = 1'b1;
    rd_key = key;
    e.data = d; e.oor = oor; e.key = key;
    sb.push_back(e);
    pend = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [KEY_W-1:0] key, input logic [DATA_W-1:0] d);
    wr_en = 1'b1;
    wr_key = key;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    $display("write key=%0d data=%02h", key, d);
  endtask

  // Counts cycles with busy high (bounded).
  task automatic count_busy(input string tag);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, n, DEPTH);
    $display("%s busy cycles=%0d", tag, n);
  endtask

  initial begin
    reset = 1'b1; init_req = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    rd_key = '0; wr_key = '0; wr_data = '0;
    tick(); tick();
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_data", {24'b0, rd_data}, 32'd0);
    chk("rst_oor", {31'b0, rd_oor}, 32'd0);
    reset = 1'b0;
    count_busy("init_len");

    do_read(8'd0, 8'h20, 1'b0);
    do_read(8'd16, 8'd2, 1'b0);
    do_read(8'd30, 8'd136, 1'b0);
    do_read(8'd31, 8'd0, 1'b0);
    do_read(8'd40, 8'd0, 1'b1);
    do_read(8'd5, 8'h5B, 1'b0);

    do_write(8'd17, 8'h77);
    do_read(8'd17, 8'h77, 1'b0);
    do_write(8'd50, 8'hAB);
    do_read(8'd18, 8'd104, 1'b0);
    do_read(8'd31, 8'd0, 1'b0);

    // Same-cycle read and write to key 3.
    wr_en = 1'b1; wr_key = 8'd3; wr_data = 8'h99;
`ifdef PROG_LUT_FWD_EN
    do_read(8'd3, 8'h99, 1'b0);
`else
    do_read(8'd3, 8'h23, 1'b0);
`endif
    wr_en = 1'b0;
    do_read(8'd3, 8'h99, 1'b0);

    do_write(8'd0, 8'h11);
    do_read(8'd0, 8'h11, 1'b0);
    init_req = 1'b1; rd_en = 1'b1; rd_key = 8'd0;
    tick();
    init_req = 1'b0; rd_en = 1'b0;
    count_busy("reinit_len");
    do_read(8'd0, 8'h20, 1'b0);

    // Reset part-way through INIT, with user traffic held active throughout.
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    rd_en = 1'b1; rd_key = 8'd2; wr_en = 1'b1; wr_key = 8'd1; wr_data = 8'hEE;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    chk("midrst_data", {24'b0, rd_data}, 32'd0);
    reset = 1'b0;
    count_busy("rst_init_len");
    rd_en = 1'b0; wr_en = 1'b0;
    do_read(8'd1, 8'h21, 1'b0);
    do_read(8'd2, 8'h22, 1'b0);
    do_read(8'd17, 8'd4, 1'b0);
    do_read(8'd3, 8'h23, 1'b0);
    tick();
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_lut.md
# prog_lut

Parametrised, runtime-programmable lookup table that replaces the fixed constant/branch-target table in the SIAA processor datapath. Holds DEPTH entries of DATA_W bits. Self-initialises from a packaged default image after reset or on request. Serves registered single-cycle reads and accepts writes, so programs can retarget branches and constants without re-synthesis.

## Interface
Parameters:
- KEY_W, 8: key width.
- DATA_W, 8: entry width.
- DEPTH, 32: number of entries; must be ≤ 2^KEY_W and ≥ 2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- init_req  in  1  pulse: reload the default image (honoured in READY only).
- busy  out  1  high while the default image is loading.
- rd_en  in  1  read request.
- rd_key  in  KEY_W  read index.
- rd_data  out  DATA_W  registered read result.
- rd_valid  out  1  one-cycle strobe: rd_data/rd_oor are valid.
- rd_oor  out  1  read key was ≥ DEPTH.
- wr_en  in  1  write request.
- wr_key  in  KEY_W  write index.
- wr_data  in  DATA_W  write value.

## Operation
- FSM states: INIT, READY.
- reset: state←INIT, init counter←0. Outputs: busy=1, rd_data=0, rd_valid=0, rd_oor=0.
- INIT: each cycle writes DEFAULT_IMAGE[cnt] (zero-extended/truncated to DATA_W; 0 for indices beyond the image length) to entry cnt, then cnt++. After writing entry DEPTH-1 → READY.
- INIT: rd_en, wr_en and init_req are ignored; rd_valid stays 0; writes are dropped, not queued.
- READY: busy=0. init_req=1 → INIT with cnt←0. init_req has priority: a rd_en/wr_en in the same cycle is ignored.
- Read (READY, rd_en): rd_key < DEPTH → rd_data←entry, rd_oor←0. rd_key ≥ DEPTH → rd_data←0, rd_oor←1. rd_valid=1 for exactly the following cycle.
- No read: rd_valid←0; rd_data and rd_oor hold their last values.
- Write (READY, wr_en, wr_key < DEPTH): entry updated at the edge. wr_key ≥ DEPTH: silently dropped.
- Read and write in the same cycle to different keys: both performed.
- Same key: see Configuration.
- reset during INIT or READY: restarts INIT from entry 0. The previous contents are fully overwritten.
- Key comparison is unsigned, at full KEY_W width. No wrap-around of out-of-range keys.

## Timing
- Read latency: 1 cycle (request at edge N, rd_valid/rd_data visible after edge N+1).
- Write visible to a read issued on the cycle after the write edge.
- INIT duration: exactly DEPTH cycles. busy falls on the cycle after entry DEPTH-1 is written. After reset release, the first accepted read is at cycle DEPTH.
- Throughput: one read and one write per cycle in READY.
- No combinational path from any input to any output.

## Configuration
- PROG_LUT_FWD_EN defined: a same-cycle read and write to the same in-range key returns wr_data on rd_data (write-first forwarding).
- PROG_LUT_FWD_EN undefined: that read returns the pre-write value (read-first). The new value is visible from the next read.
- All other behaviour is identical in both builds.

## Structure
- Package prog_lut_pkg:
  - DEFAULT_IMAGE constant array (8-bit values):
    - indices 0–15: constants 0x20, 0x21, 0x22, 0x23, 0x40, 0x5B, 0x6D, 0x8E, 0xA8, 0xAA, 0xC8, 0xCC, 0xE0, 0xE8, 0xF0, 0xFE.
    - indices 16–30: branch targets 2, 4, 104, 137, 141, 145, 147, 154, 9, 17, 58, 68, 110, 120, 136.
  - DEFAULT_LEN = 31.
  - State enum lut_state_t {INIT, READY}.
- Sub-module lut_init_seq: owns the FSM and init counter; produces busy plus the internal init write port (address/data/enable) that muxes onto the storage write port.
- Storage array and read register stay in prog_lut.

## Test plan
- Reset, then hold rd_en=0 → busy=1 for 32 cycles, busy=0 on cycle 32. After that, read key 0 → 0x20, key 16 → 2, key 30 → 136, key 31 → 0.
- Read key 40 (DEPTH=32) → rd_valid=1, rd_oor=1, rd_data=0. Next read of key 5 → rd_oor=0, rd_data=0x5B.
- Write key 17 ← 0x77, read key 17 next cycle → 0x77. Write to key 50 → no entry changes (spot-check keys 18 and 31).
- Same-cycle write key 3 ← 0x99 and read key 3 → 0x99 with PROG_LUT_FWD_EN, 0x23 without. Either way, the following read → 0x99.
- After writing key 0 ← 0x11, pulse init_req with rd_en=1 → no rd_valid that cycle, busy=1 for 32 cycles. Then read key 0 → 0x20.
- Assert reset at INIT cycle 10, with rd_en and wr_en active during INIT → all ignored. INIT restarts; busy stays high 32 cycles after reset release; default contents intact.
